// File: rtl/usb_fx2_slavefifo_emu_pkg.sv
// Shared constants for the FX2 slave-FIFO emulator: bus width, FIFOADR codes
// and a saturating event-counter helper.
package usb_fx2_slavefifo_emu_pkg;

  localparam int USB_DATA_NBIT = 16;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/usb_fx2_slavefifo_emu_if.sv
// Slave-FIFO pins plus the host-side push/pop streams of the FX2 emulator.
// master = usb_slavefifo/host side, slave = the emulator.
interface usb_fx2_slavefifo_emu_if
  import usb_fx2_slavefifo_emu_pkg::*;
#(
  parameter int DATA_NBIT = USB_DATA_NBIT
);
  logic                 usb_sloe_n;
  logic                 usb_slrd_n;
  logic                 usb_slwr_n;
  logic                 usb_pkend_n;
  logic [1:0]           usb_fifoadr;
  logic [DATA_NBIT-1:0] usb_db_i;
  logic [DATA_NBIT-1:0] usb_db_o;
  logic                 usb_db_oe;
  logic                 usb_flagb;
  logic                 usb_flagc;

  logic                 host_out_vd;
  logic [DATA_NBIT-1:0] host_out_data;
  logic                 host_out_rdy;
  logic                 host_in_vd;
  logic [DATA_NBIT-1:0] host_in_data;
  logic                 host_in_last;
  logic                 host_in_rdy;

  modport master (
    output usb_sloe_n, usb_slrd_n, usb_slwr_n, usb_pkend_n, usb_fifoadr, usb_db_i,
    input  usb_db_o, usb_db_oe, usb_flagb, usb_flagc,
    output host_out_vd, host_out_data, host_in_rdy,
    input  host_out_rdy, host_in_vd, host_in_data, host_in_last
  );

  modport slave (
    input  usb_sloe_n, usb_slrd_n, usb_slwr_n, usb_pkend_n, usb_fifoadr, usb_db_i,
    output usb_db_o, usb_db_oe, usb_flagb, usb_flagc,
    input  host_out_vd, host_out_data, host_in_rdy,
    output host_out_rdy, host_in_vd, host_in_data, host_in_last
  );
endinterface

// File: rtl/usb_fx2_slavefifo_emu_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a patch port that
// rewrites the most recently written word (used to tag a packet's last word).
module emu_sync_fifo #(
  parameter int W  = 16,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          patch,
  input  logic [W-1:0]  patch_data,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [2**AW];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [AW-1:0] last_addr;
  logic          pop_ok;
  logic          push_ok;

  assign count     = wr_ptr_reg - rd_ptr_reg;
  assign pop_ok    = pop && (count != '0);
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign push_ok   = push && (!count[AW] || pop_ok);
  assign last_addr = wr_ptr_reg[AW-1:0] - AW'(1);
  assign head      = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)    mem[wr_ptr_reg[AW-1:0]] <= push_data;
    else if (patch) mem[last_addr]          <= patch_data;
  end
endmodule

// File: rtl/usb_fx2_slavefifo_emu.sv
// FX2 device-side emulation: EP2 (host->FPGA) and EP6 (FPGA->host) endpoint
// FIFOs with packet commit, auto-commit, ZLP and illegal-strobe accounting.
module usb_fx2_slavefifo_emu
  import usb_fx2_slavefifo_emu_pkg::*;
#(
  parameter int DATA_NBIT = USB_DATA_NBIT,
  parameter int OUT_AW    = 9,
  parameter int IN_AW     = 9,
  parameter int PKT_WORDS = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  usb_fx2_slavefifo_emu_if.slave    bus,
  output logic [7:0]                zlp_cnt,
  output logic [7:0]                rd_uflow_cnt,
  output logic [7:0]                wr_oflow_cnt
);
  localparam logic [IN_AW:0] PKT_LAST = (IN_AW+1)'(PKT_WORDS - 1);

  logic                 ep2_sel, ep6_sel, rd_en, wr_en, pkend_en;
  logic [OUT_AW:0]      ep2_count;
  logic [DATA_NBIT-1:0] ep2_head;
  logic                 ep2_empty, ep2_full, ep2_push;

  logic [IN_AW:0]       ep6_count;
  logic [DATA_NBIT:0]   ep6_head;
  logic                 ep6_full, host_pop, wr_ok, close_wr, patch, commit;
  logic [IN_AW:0]       committed_cnt_reg, uncom_cnt_reg, uncom_plus;
  logic [DATA_NBIT-1:0] last_data_reg;

  assign ep2_sel  = (bus.usb_fifoadr == EP2_ADDR);
  assign ep6_sel  = (bus.usb_fifoadr == EP6_ADDR);
  assign rd_en    = !bus.usb_slrd_n  && ep2_sel;
  assign wr_en    = !bus.usb_slwr_n  && ep6_sel;
  assign pkend_en = !bus.usb_pkend_n && ep6_sel;

  assign ep2_empty = (ep2_count == '0);
  assign ep2_full  = ep2_count[OUT_AW];
  assign ep2_push  = bus.host_out_vd && !ep2_full;

  emu_sync_fifo #(.W(DATA_NBIT), .AW(OUT_AW)) u_ep2 (
    .clk(clk), .rst_n(rst_n),
    .push(ep2_push), .push_data(bus.host_out_data),
    .pop(rd_en), .patch(1'b0), .patch_data('0),
    .head(ep2_head), .count(ep2_count)
  );

  assign bus.host_out_rdy = !ep2_full;
  assign bus.usb_db_o     = ep2_empty ? '0 : ep2_head;
  assign bus.usb_db_oe    = !bus.usb_sloe_n && ep2_sel;
  assign bus.usb_flagb    = !ep2_empty;

  // Only committed words are visible to the host; occupancy counts all words.
  assign ep6_full   = ep6_count[IN_AW];
  assign host_pop   = (committed_cnt_reg != '0) && bus.host_in_rdy;
  assign wr_ok      = wr_en && (!ep6_full || host_pop);
  assign close_wr   = wr_ok && (pkend_en || (uncom_cnt_reg == PKT_LAST));
  assign patch      = pkend_en && !wr_ok && (uncom_cnt_reg != '0);
  assign commit     = close_wr || patch;
  assign uncom_plus = uncom_cnt_reg + {{IN_AW{1'b0}}, wr_ok};

  emu_sync_fifo #(.W(DATA_NBIT+1), .AW(IN_AW)) u_ep6 (
    .clk(clk), .rst_n(rst_n),
    .push(wr_ok), .push_data({close_wr, bus.usb_db_i}),
    .pop(host_pop), .patch(patch), .patch_data({1'b1, last_data_reg}),
    .head(ep6_head), .count(ep6_count)
  );

  assign bus.host_in_vd   = (committed_cnt_reg != '0);
  assign bus.host_in_data = bus.host_in_vd ? ep6_head[DATA_NBIT-1:0] : '0;
  assign bus.host_in_last = bus.host_in_vd && ep6_head[DATA_NBIT];
  assign bus.usb_flagc    = !ep6_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      committed_cnt_reg <= '0;
      uncom_cnt_reg     <= '0;
      last_data_reg     <= '0;
      zlp_cnt           <= '0;
      rd_uflow_cnt      <= '0;
      wr_oflow_cnt      <= '0;
    end else begin
      committed_cnt_reg <= committed_cnt_reg - {{IN_AW{1'b0}}, host_pop}
                           + (commit ? uncom_plus : '0);
      uncom_cnt_reg     <= commit ? '0 : uncom_plus;
      if (wr_ok) last_data_reg <= bus.usb_db_i;
      if (pkend_en && !wr_ok && (uncom_cnt_reg == '0)) zlp_cnt <= sat_inc8(zlp_cnt);
      if (rd_en && ep2_empty)  rd_uflow_cnt <= sat_inc8(rd_uflow_cnt);
      if (wr_en && !wr_ok)     wr_oflow_cnt <= sat_inc8(wr_oflow_cnt);
    end
  end
endmodule

// File: tb/tb_usb_fx2_slavefifo_emu.sv
// Directed bench for the FX2 slave-FIFO emulator: EP2 reads, underflow,
// EP6 PKEND/auto-commit/ZLP, full/overflow and mid-packet reset.
module tb_usb_fx2_slavefifo_emu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] zlp_cnt, rd_uflow_cnt, wr_oflow_cnt;
  int n_checks = 0;
  int n_fail = 0;

  usb_fx2_slavefifo_emu_if #(.DATA_NBIT(16)) bus ();

  usb_fx2_slavefifo_emu #(
    .DATA_NBIT(16), .OUT_AW(9), .IN_AW(9), .PKT_WORDS(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .zlp_cnt(zlp_cnt), .rd_uflow_cnt(rd_uflow_cnt), .wr_oflow_cnt(wr_oflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (bus.usb_flagb !== 1'b0) begin n_fail++; $display("FAIL reset_flagb got %b exp 0", bus.usb_flagb); end
    n_checks++; if (bus.usb_flagc !== 1'b1) begin n_fail++; $display("FAIL reset_flagc got %b exp 1", bus.usb_flagc); end
    n_checks++; if (bus.usb_db_oe !== 1'b0 || bus.usb_db_o !== 16'h0) begin n_fail++; $display("FAIL reset_db got oe=%b db=%h exp 0/0000", bus.usb_db_oe, bus.usb_db_o); end
    n_checks++; if (bus.host_out_rdy !== 1'b1 || bus.host_in_vd !== 1'b0 || bus.host_in_last !== 1'b0) begin n_fail++; $display("FAIL reset_host got rdy=%b vd=%b last=%b exp 1/0/0", bus.host_out_rdy, bus.host_in_vd, bus.host_in_last); end
    n_checks++; if ({zlp_cnt, rd_uflow_cnt, wr_oflow_cnt} !== 24'h0) begin n_fail++; $display("FAIL reset_cnt got %h exp 000000", {zlp_cnt, rd_uflow_cnt, wr_oflow_cnt}); end
    tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_ep2_read();
    for (int i = 1; i <= 4; i++) begin
      bus.host_out_vd = 1'b1; bus.host_out_data = 16'(i);
      tick();
      if (i == 1) begin
        n_checks++; if (bus.usb_flagb !== 1'b1) begin n_fail++; $display("FAIL ep2_flagb_rise got %b exp 1", bus.usb_flagb); end
      end
    end
    bus.host_out_vd = 1'b0;
    bus.usb_fifoadr = 2'b00; bus.usb_sloe_n = 1'b0; bus.usb_slrd_n = 1'b0;
    #1;
    n_checks++; if (bus.usb_db_oe !== 1'b1) begin n_fail++; $display("FAIL ep2_oe got %b exp 1", bus.usb_db_oe); end
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (bus.usb_db_o !== 16'(k)) begin n_fail++; $display("FAIL ep2_word%0d got %h exp %h", k, bus.usb_db_o, 16'(k)); end
      tick();
    end
    bus.usb_slrd_n = 1'b1;
    n_checks++; if (bus.usb_flagb !== 1'b0 || bus.usb_db_o !== 16'h0) begin n_fail++; $display("FAIL ep2_empty_after got flagb=%b db=%h exp 0/0000", bus.usb_flagb, bus.usb_db_o); end
    n_checks++; if (rd_uflow_cnt !== 8'd0) begin n_fail++; $display("FAIL ep2_no_uflow got %0d exp 0", rd_uflow_cnt); end
    bus.usb_sloe_n = 1'b1;
    $display("test_ep2_read done");
  endtask

  task automatic test_ep2_underflow();
    bus.usb_fifoadr = 2'b00; bus.usb_slrd_n = 1'b0;
    repeat (3) tick();
    bus.usb_slrd_n = 1'b1;
    n_checks++; if (rd_uflow_cnt !== 8'd3) begin n_fail++; $display("FAIL uflow_cnt got %0d exp 3", rd_uflow_cnt); end
    n_checks++; if (bus.usb_db_o !== 16'h0 || bus.usb_flagb !== 1'b0) begin n_fail++; $display("FAIL uflow_state got db=%h flagb=%b exp 0000/0", bus.usb_db_o, bus.usb_flagb); end
    $display("test_ep2_underflow done");
  endtask

  task automatic test_ep6_pkend();
    logic [16:0] exp_w [3];
    exp_w[0] = {1'b0, 16'h00A0}; exp_w[1] = {1'b0, 16'h00A1}; exp_w[2] = {1'b1, 16'h00A2};
    bus.usb_fifoadr = 2'b10; bus.usb_slwr_n = 1'b0;
    for (int i = 0; i < 3; i++) begin bus.usb_db_i = 16'hA0 + 16'(i); tick(); end
    bus.usb_slwr_n = 1'b1;
    tick();
    n_checks++; if (bus.host_in_vd !== 1'b0) begin n_fail++; $display("FAIL pkend_uncommitted got vd=%b exp 0", bus.host_in_vd); end
    bus.usb_pkend_n = 1'b0;
    tick();
    bus.usb_pkend_n = 1'b1;
    n_checks++; if (bus.host_in_vd !== 1'b1) begin n_fail++; $display("FAIL pkend_commit got vd=%b exp 1", bus.host_in_vd); end
    bus.host_in_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({bus.host_in_last, bus.host_in_data} !== exp_w[i]) begin n_fail++; $display("FAIL pkend_pop%0d got %h exp %h", i, {bus.host_in_last, bus.host_in_data}, exp_w[i]); end
      tick();
    end
    bus.host_in_rdy = 1'b0;
    n_checks++; if (bus.host_in_vd !== 1'b0 || zlp_cnt !== 8'd0) begin n_fail++; $display("FAIL pkend_drained got vd=%b zlp=%0d exp 0/0", bus.host_in_vd, zlp_cnt); end
    $display("test_ep6_pkend done");
  endtask

  task automatic test_auto_commit();
    int bad = 0;
    bus.usb_fifoadr = 2'b10; bus.usb_slwr_n = 1'b0;
    for (int i = 1; i <= 256; i++) begin bus.usb_db_i = 16'h2000 + 16'(i); tick(); end
    bus.usb_slwr_n = 1'b1;
    n_checks++; if (bus.host_in_vd !== 1'b1) begin n_fail++; $display("FAIL auto_commit got vd=%b exp 1", bus.host_in_vd); end
    bus.usb_pkend_n = 1'b0;
    tick();
    bus.usb_pkend_n = 1'b1;
    n_checks++; if (zlp_cnt !== 8'd1) begin n_fail++; $display("FAIL auto_zlp got %0d exp 1", zlp_cnt); end
    bus.host_in_rdy = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      if ({bus.host_in_vd, bus.host_in_last, bus.host_in_data} !== {1'b1, (i == 256), 16'h2000 + 16'(i)}) begin
        if (bad == 0) $display("FAIL auto_word%0d got vd=%b last=%b data=%h exp 1/%b/%h", i, bus.host_in_vd, bus.host_in_last, bus.host_in_data, (i == 256), 16'h2000 + 16'(i));
        bad++;
      end
      tick();
    end
    bus.host_in_rdy = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL auto_words got %0d bad words exp 0", bad); end
    n_checks++; if (bus.host_in_vd !== 1'b0) begin n_fail++; $display("FAIL auto_drained got vd=%b exp 0", bus.host_in_vd); end
    $display("test_auto_commit done");
  endtask

  task automatic test_ep6_full();
    int bad = 0;
    bus.usb_fifoadr = 2'b10; bus.usb_slwr_n = 1'b0;
    for (int i = 0; i < 512; i++) begin
      bus.usb_db_i = 16'h1000 + 16'(i);
      tick();
      if (i == 510) begin
        n_checks++; if (bus.usb_flagc !== 1'b1) begin n_fail++; $display("FAIL full_511 got flagc=%b exp 1", bus.usb_flagc); end
      end
    end
    n_checks++; if (bus.usb_flagc !== 1'b0) begin n_fail++; $display("FAIL full_512 got flagc=%b exp 0", bus.usb_flagc); end
    bus.usb_db_i = 16'hDEAD;
    tick();
    n_checks++; if (wr_oflow_cnt !== 8'd1 || bus.usb_flagc !== 1'b0) begin n_fail++; $display("FAIL oflow got cnt=%0d flagc=%b exp 1/0", wr_oflow_cnt, bus.usb_flagc); end
    bus.usb_db_i = 16'hBEEF; bus.host_in_rdy = 1'b1;
    tick();
    bus.host_in_rdy = 1'b0; bus.usb_slwr_n = 1'b1;
    n_checks++; if (bus.usb_flagc !== 1'b0 || wr_oflow_cnt !== 8'd1) begin n_fail++; $display("FAIL full_popwr got flagc=%b oflow=%0d exp 0/1", bus.usb_flagc, wr_oflow_cnt); end
    bus.usb_pkend_n = 1'b0;
    tick();
    bus.usb_pkend_n = 1'b1;
    n_checks++; if (zlp_cnt !== 8'd1) begin n_fail++; $display("FAIL full_pkend got zlp=%0d exp 1", zlp_cnt); end
    bus.host_in_rdy = 1'b1;
    for (int j = 1; j <= 512; j++) begin
      logic [16:0] exp_w;
      exp_w = (j == 512) ? {1'b1, 16'hBEEF} : {(j == 255 || j == 511), 16'h1000 + 16'(j)};
      if ({bus.host_in_last, bus.host_in_data} !== exp_w || bus.host_in_vd !== 1'b1) begin
        if (bad == 0) $display("FAIL full_word%0d got vd=%b %h exp %h", j, bus.host_in_vd, {bus.host_in_last, bus.host_in_data}, exp_w);
        bad++;
      end
      tick();
    end
    bus.host_in_rdy = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL full_words got %0d bad words exp 0", bad); end
    n_checks++; if (bus.usb_flagc !== 1'b1 || bus.host_in_vd !== 1'b0) begin n_fail++; $display("FAIL full_drained got flagc=%b vd=%b exp 1/0", bus.usb_flagc, bus.host_in_vd); end
    $display("test_ep6_full done");
  endtask

  task automatic test_reset_midpacket();
    bus.host_out_vd = 1'b1; bus.host_out_data = 16'h0055;
    tick();
    bus.host_out_vd = 1'b0;
    bus.usb_fifoadr = 2'b10; bus.usb_slwr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin bus.usb_db_i = 16'h3000 + 16'(i); tick(); end
    bus.usb_slwr_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.usb_flagb !== 1'b0 || bus.usb_flagc !== 1'b1 || bus.usb_db_o !== 16'h0 || bus.usb_db_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pins got flagb=%b flagc=%b db=%h oe=%b exp 0/1/0000/0", bus.usb_flagb, bus.usb_flagc, bus.usb_db_o, bus.usb_db_oe); end
    n_checks++; if (bus.host_out_rdy !== 1'b1 || bus.host_in_vd !== 1'b0 || bus.host_in_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_host got rdy=%b vd=%b last=%b exp 1/0/0", bus.host_out_rdy, bus.host_in_vd, bus.host_in_last); end
    n_checks++; if ({zlp_cnt, rd_uflow_cnt, wr_oflow_cnt} !== 24'h0) begin n_fail++; $display("FAIL rst_mid_cnt got %h exp 000000", {zlp_cnt, rd_uflow_cnt, wr_oflow_cnt}); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.host_in_vd !== 1'b0 || bus.usb_flagc !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after got vd=%b flagc=%b exp 0/1", bus.host_in_vd, bus.usb_flagc); end
    $display("test_reset_midpacket done");
  endtask

  initial begin
    bus.usb_sloe_n = 1'b1; bus.usb_slrd_n = 1'b1; bus.usb_slwr_n = 1'b1; bus.usb_pkend_n = 1'b1;
    bus.usb_fifoadr = 2'b01; bus.usb_db_i = '0;
    bus.host_out_vd = 1'b0; bus.host_out_data = '0; bus.host_in_rdy = 1'b0;
    test_reset();
    test_ep2_read();
    test_ep2_underflow();
    test_ep6_pkend();
    test_auto_commit();
    test_ep6_full();
    test_reset_midpacket();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
